// File: rtl/seq_pkg.sv
// Shared definitions for the stage sequencer: FSM state encoding and
// the stage-index width derivation.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_e;

  // Index width never collapses to zero, even for a single stage.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stage_sequencer_next_stage_find.sv
// Priority encoder: lowest enabled stage strictly above idx, or the lowest
// enabled stage overall when first is set.
module next_stage_find #(
  parameter int N_STAGES = 3,
  parameter int IDX_W    = 2
) (
  input  logic [N_STAGES-1:0] mask,
  input  logic [IDX_W-1:0]    idx,
  input  logic                first,
  output logic [IDX_W-1:0]    next_idx,
  output logic                valid
);

  always_comb begin
    next_idx = '0;
    valid    = 1'b0;
    // Scan downwards so the lowest qualifying stage is the last one written.
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(idx)))) begin
        next_idx = IDX_W'(i);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Moore sequencer that launches enabled stages in ascending order over
// start/done handshakes, with a per-stage watchdog and abort.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int  N_STAGES = 3,
  parameter int  TO_W     = 8,
  localparam int IDX_W    = idx_width(N_STAGES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [N_STAGES-1:0] stage_en,
  input  logic [TO_W-1:0]     timeout,
  input  logic [N_STAGES-1:0] done_i,
  output logic [N_STAGES-1:0] start_o,
  output logic                busy,
  output logic                Done,
  output logic                error,
  output logic [IDX_W-1:0]    err_stage
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_STAGES-1:0]   mask_q, mask_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]      err_stage_q, err_stage_d;

  logic                  find_first;
  logic [N_STAGES-1:0]   find_mask;
  logic [IDX_W-1:0]      find_idx;
  logic                  find_valid;

  // In IDLE the encoder looks at the incoming mask for the first stage;
  // otherwise it walks the captured mask upward from the current stage.
  assign find_first = (state_q == S_IDLE);
  assign find_mask  = find_first ? stage_en : mask_q;

  next_stage_find #(
    .N_STAGES (N_STAGES),
    .IDX_W    (IDX_W)
  ) u_find (
    .mask     (find_mask),
    .idx      (idx_q),
    .first    (find_first),
    .next_idx (find_idx),
    .valid    (find_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      to_q        <= '0;
      cnt_q       <= '0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      to_q        <= to_d;
      cnt_q       <= cnt_d;
      err_stage_q <= err_stage_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    to_d        = to_q;
    cnt_d       = cnt_q;
    err_stage_d = err_stage_q;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_d      = stage_en;
            to_d        = timeout;
            err_stage_d = '0;
            if (find_valid) begin
              idx_d   = find_idx;
              state_d = S_START;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_START: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // Done beats an expiring watchdog in the same cycle.
          if (done_i[idx_q]) begin
            if (find_valid) begin
              idx_d   = find_idx;
              state_d = S_START;
            end else begin
              state_d = S_DONE;
            end
          end else if ((to_q != '0) && (cnt_q == to_q - TO_W'(1))) begin
            err_stage_d = idx_q;
            state_d     = S_ERROR;
          end else if (cnt_q != {TO_W{1'b1}}) begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_ERROR: begin
          if (start) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    start_o   = (state_q == S_START) ? (N_STAGES'(1) << idx_q) : '0;
    busy      = (state_q == S_START) || (state_q == S_WAIT);
    Done      = (state_q == S_DONE);
    error     = (state_q == S_ERROR);
    err_stage = err_stage_q;
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer: each run's cycle-by-cycle outputs are
// predicted from per-stage response latencies using the sequencing rules.
module tb_stage_sequencer;

  localparam int N     = 3;
  localparam int TO_W  = 8;
  localparam int IDX_W = 2;
  localparam int MAXC  = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [N-1:0]     stage_en;
  logic [TO_W-1:0]  timeout;
  logic [N-1:0]     done_i;
  logic [N-1:0]     start_o;
  logic             busy;
  logic             Done;
  logic             error;
  logic [IDX_W-1:0] err_stage;

  int total = 0;
  int bad   = 0;

  // Per-stage latency in WAIT cycles until done (0 = never answers).
  int lat [N];

  // Expected per-cycle behaviour, cycle 1 = first cycle after the start edge.
  logic [N-1:0] e_so   [MAXC];
  int           cur    [MAXC];
  bit           dval   [MAXC];

  always #5 clk = ~clk;

  stage_sequencer #(
    .N_STAGES (N),
    .TO_W     (TO_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .stage_en  (stage_en),
    .timeout   (timeout),
    .done_i    (done_i),
    .start_o   (start_o),
    .busy      (busy),
    .Done      (Done),
    .error     (error),
    .err_stage (err_stage)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    stage_en = '0; timeout = '0; done_i = '0;
    #1;
    total++;
    if ({start_o, busy, Done, error, err_stage} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {start_o, busy, Done, error, err_stage});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({start_o, busy, Done, error, err_stage} !== '0) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=0", {start_o, busy, Done, error, err_stage});
    end
    $display("test_reset checked");
  endtask

  // One run: stimulus from lat[] and the given mask/timeout, expectations
  // derived from the sequencing rules; errors are acknowledged with start.
  task automatic test_sequence(input string name, input logic [N-1:0] mask,
                               input int to, input bit noise);
    int  t, endc, estage;
    bit  err;
    logic [N-1:0] d;
    for (int c = 0; c < MAXC; c++) begin
      e_so[c] = '0; cur[c] = -1; dval[c] = 1'b0;
    end
    t = 1; err = 1'b0; estage = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !err) begin
        e_so[t] = N'(1) << i;
        if (lat[i] > 0 && (to == 0 || lat[i] <= to)) begin
          for (int w = 1; w <= lat[i]; w++) cur[t + w] = i;
          dval[t + lat[i]] = 1'b1;
          t = t + lat[i] + 1;
        end else begin
          for (int w = 1; w <= to; w++) cur[t + w] = i;
          t = t + to + 1;
          err = 1'b1;
          estage = i;
        end
      end
    end
    endc = t;

    @(negedge clk);
    start = 1'b1; stage_en = mask; timeout = TO_W'(to); done_i = '0;
    @(negedge clk);
    start = 1'b0;
    // Scramble the run inputs after capture; the run must not see them.
    stage_en = N'($urandom); timeout = TO_W'($urandom);
    for (int c = 1; c <= endc; c++) begin
      total++;
      if (start_o !== e_so[c]) begin
        bad++;
        $display("FAIL %s start_o cyc=%0d got=%b want=%b", name, c, start_o, e_so[c]);
      end
      total++;
      if (busy !== (c < endc)) begin
        bad++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", name, c, busy, (c < endc));
      end
      total++;
      if (Done !== (!err && c == endc)) begin
        bad++;
        $display("FAIL %s Done cyc=%0d got=%b want=%b", name, c, Done, (!err && c == endc));
      end
      total++;
      if (error !== (err && c == endc)) begin
        bad++;
        $display("FAIL %s error cyc=%0d got=%b want=%b", name, c, error, (err && c == endc));
      end
      total++;
      if (err_stage !== ((err && c == endc) ? IDX_W'(estage) : IDX_W'(0))) begin
        bad++;
        $display("FAIL %s err_stage cyc=%0d got=%0d want=%0d", name, c, err_stage,
                 (err && c == endc) ? estage : 0);
      end
      d = noise ? N'($urandom) : '0;
      if (cur[c] >= 0) d[cur[c]] = dval[c];
      done_i = d;
      start  = noise && (c < endc) && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    done_i = '0;
    if (!err) begin
      total++;
      if ({start_o, busy, Done, error} !== '0) begin
        bad++;
        $display("FAIL %s post_done got=%b want=0", name, {start_o, busy, Done, error});
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (error !== 1'b1 || err_stage !== IDX_W'(estage) || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s error_hold got=%b/%0d want=1/%0d", name, error, err_stage, estage);
        end
        if (k == 0) @(negedge clk);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({start_o, busy, Done, error} !== '0 || err_stage !== IDX_W'(estage)) begin
          bad++;
          $display("FAIL %s ack got=%b es=%0d want=0 es=%0d", name,
                   {start_o, busy, Done, error}, err_stage, estage);
        end
        @(negedge clk);
      end
    end
    $display("%s mask=%b to=%0d lat=%0d,%0d,%0d end=%0d err=%0d", name, mask, to,
             lat[0], lat[1], lat[2], endc, err);
  endtask

  task automatic test_directed();
    lat = '{1, 1, 1};
    test_sequence("all_enabled", 3'b111, 0, 1'b0);
    test_sequence("skip_mid", 3'b101, 0, 1'b0);
    test_sequence("empty_mask", 3'b000, 0, 1'b0);
    lat = '{2, 0, 1};
    test_sequence("timeout_s1", 3'b111, 4, 1'b0);
    lat = '{1, 4, 3};
    test_sequence("late_done", 3'b111, 4, 1'b1);
    lat = '{3, 5, 1};
    test_sequence("done_eq_to_plus1", 3'b011, 4, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1; stage_en = 3'b111; timeout = '0; done_i = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    done_i = 3'b001;
    @(negedge clk);
    done_i = '0;
    total++;
    if (start_o !== 3'b010) begin
      bad++;
      $display("FAIL abort_s1_start got=%b want=010", start_o);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b1; done_i = 3'b010;
    @(negedge clk);
    abort = 1'b0; done_i = '0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({start_o, busy, Done, error} !== '0) begin
        bad++;
        $display("FAIL abort_wait cyc=%0d got=%b want=0", k, {start_o, busy, Done, error});
      end
      @(negedge clk);
    end
    start = 1'b1; stage_en = 3'b100; timeout = TO_W'(2);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (error !== 1'b1 || err_stage !== 2'd2) begin
      bad++;
      $display("FAIL abort_err_setup got=%b/%0d want=1/2", error, err_stage);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (error !== 1'b0 || busy !== 1'b0 || err_stage !== 2'd2) begin
      bad++;
      $display("FAIL abort_from_error got=%b/%b/%0d want=0/0/2", error, busy, err_stage);
    end
    $display("test_abort checked");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; stage_en = 3'b111; timeout = '0; done_i = '0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (start_o !== 3'b001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre got=%b/%b want=001/1", start_o, busy);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({start_o, busy, Done, error, err_stage} !== '0) begin
      bad++;
      $display("FAIL areset_immediate got=%b want=0", {start_o, busy, Done, error, err_stage});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({start_o, busy, Done, error} !== '0) begin
      bad++;
      $display("FAIL areset_idle got=%b want=0", {start_o, busy, Done, error});
    end
    start = 1'b1; stage_en = 3'b010;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (start_o !== 3'b010 || busy !== 1'b1) begin
      bad++;
      $display("FAIL areset_relaunch got=%b/%b want=010/1", start_o, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("test_async_reset checked");
  endtask

  task automatic test_random_runs(input int runs);
    logic [N-1:0] m;
    int to;
    for (int r = 0; r < runs; r++) begin
      m  = N'($urandom);
      to = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        if (to != 0 && $urandom_range(0, 4) == 0) lat[i] = 0;
        else lat[i] = $urandom_range(1, 8);
      end
      test_sequence("random", m, to, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_async_reset();
    test_random_runs(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
